vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Free-running VGA raster timing generator for the 48 MHz demo core. It produces the beam position and early display-enable that drive the pixel/colour pipeline. It also produces hsync, vsync and display-enable delayed by a fixed pipeline depth, so they line up with the 2-bit-per-channel colour reaching the TinyVGA PMOD pins. It also keeps the frame counter that animates the demo, with pause support.

## Interface
Parameters:
- H_ACTIVE, 1220: visible clocks per line.
- H_FP, 30: horizontal front porch, in clocks.
- H_SYNC, 183: hsync pulse width, in clocks.
- H_BP, 92: horizontal back porch; H_TOTAL = 1525.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync width, in lines.
- V_BP, 33: vertical back porch; V_TOTAL = 525, about 59.95 Hz.
- PIPE_DELAY, 2: colour-pipeline latency in clocks (0..15) that the delayed outputs are aligned to.

Ports:
- clk48  in  1  sole clock, 48 MHz.
- rst  in  1  synchronous reset, active-high.
- pause_n  in  1  0 freezes the frame counter; raster timing keeps running.
- hpos  out  11  horizontal counter, 0..H_TOTAL-1.
- vpos  out  10  vertical counter, 0..V_TOTAL-1.
- de_early  out  1  hpos<H_ACTIVE && vpos<V_ACTIVE, undelayed.
- line_start  out  1  high when hpos==0.
- frame_start  out  1  high when hpos==0 && vpos==0.
- frame  out  16  frame counter.
- hsync  out  1  active-low, delayed by PIPE_DELAY.
- vsync  out  1  active-low, delayed by PIPE_DELAY.
- de  out  1  de_early delayed by PIPE_DELAY.

## Operation
- hpos increments every clock. At H_TOTAL-1 it wraps to 0 and vpos advances; vpos wraps to 0 after V_TOTAL-1.
- Sync windows (raw, before delay):
  - hsync raw = 0 for H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC, i.e. 1250..1432.
  - vsync raw = 0 for V_ACTIVE+V_FP <= vpos < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491, for whole lines aligned to hpos==0.
- Frame counter:
  - On the clock where (hpos,vpos) wraps from (H_TOTAL-1,V_TOTAL-1) to (0,0), frame increments by 1 if pause_n==1; otherwise it holds.
  - It wraps 0xFFFF -> 0x0000.
  - pause_n is sampled only on that edge, so a mid-frame pause takes effect at the next frame boundary.
- hpos, vpos, de_early, line_start, frame_start and frame are decoded from the same counter registers and are mutually consistent in every cycle.
- Delay line:
  - The raw {hsync, vsync, de_early} vector passes through PIPE_DELAY registers.
  - With PIPE_DELAY==0 the outputs equal the raw decode combinationally.
- Reset:
  - While rst==1: hpos=0, vpos=0, frame=0.
  - de_early, line_start and frame_start are forced to 0.
  - Every delay stage is loaded with the inactive value hsync=1, vsync=1, de=0.
- Reset asserted mid-line or mid-frame aborts the raster immediately, with no partial sync pulse extension. The first cycle after rst falls is (0,0) with line_start=frame_start=de_early=1.
- Elaboration rejects a parameter set where H_TOTAL exceeds 2048 or V_TOTAL exceeds 1024.

## Timing
- Counters advance every clock; there are no stalls and no handshake.
- Latency from raw decode to hsync/vsync/de is exactly PIPE_DELAY clocks.
- The frame output updates on the same edge that moves the counters to (0,0).
- After reset, delayed outputs stay inactive for PIPE_DELAY clocks, then follow the raw decode.

## Structure
- vga_timing_pkg holds the default timing constants (H_*, V_*, derived H_TOTAL/V_TOTAL) and the field widths (11, 10, 16). The demo core and the bench share these.
- Sub-module sync_delay_line: parameter WIDTH=3 and DEPTH=PIPE_DELAY, with a reset value input bus. It is reused for any colour-side alignment.

## Test plan
- Reset release: rst high 5 clocks, then low.
  - During reset: hsync=vsync=1, de=0, frame=0.
  - First free cycle: hpos=0, vpos=0, de_early=1, frame_start=1.
  - de goes to 1 exactly 2 clocks later.
- Line timing: count clocks over one line.
  - de_early is high for 1220 clocks, then low for 305.
  - Raw hsync is low over hpos 1250..1432 (183 clocks); the pin edge falls at the clock hpos=1252.
  - The line period is 1525 clocks.
- Frame timing: run one frame.
  - vsync is low for exactly 2×1525 = 3050 clocks, starting at vpos=490 delayed 2 clocks.
  - 525 line_start pulses and 1 frame_start pulse occur per 800625 clocks.
- Pause: run 3 frames with pause_n=1, so frame=3.
  - Drop pause_n mid-frame 3 and run 2 frames: frame stays 3.
  - Raise pause_n: frame reads 4 at the next (0,0).
- Wrap: force frame=0xFFFF through a bench hierarchical deposit, then cross a boundary with pause_n=1 -> frame=0x0000.
- Mid-frame reset: assert rst at vpos=491, hpos=1300.
  - Outputs go inactive the next cycle.
  - On release the raster restarts at (0,0); frame=0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, field widths and the sync-vector type used by the demo core
// and its bench.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE_DEF = 1220;
  localparam int unsigned H_FP_DEF     = 30;
  localparam int unsigned H_SYNC_DEF   = 183;
  localparam int unsigned H_BP_DEF     = 92;
  localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int unsigned HPOS_W  = 11;
  localparam int unsigned VPOS_W  = 10;
  localparam int unsigned FRAME_W = 16;

  localparam int unsigned H_TOTAL_MAX   = 2048;
  localparam int unsigned V_TOTAL_MAX   = 1024;
  localparam int unsigned PIPE_DELAY_MAX = 15;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } sync_vec_t;

  // Value a delay stage holds while idle: both syncs deasserted (high), no display.
  localparam sync_vec_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0};

  function automatic logic in_window(input int unsigned pos, input int unsigned start,
                                     input int unsigned len);
    return (pos >= start) && (pos < start + len);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth register pipeline with a loadable reset value; DEPTH of zero is a plain wire.
module sync_delay_line #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] rst_val_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : gen_bypass
    logic unused_sync;
    assign unused_sync = ^{clk_i, rst_i, rst_val_i};
    assign q_o = d_i;
  end else begin : gen_stages
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          stage_q[i] <= rst_val_i;
        end
      end else begin
        stage_q[0] <= d_i;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster generator: beam position, early display enable, frame counter
// and sync/enable outputs delayed to line up with the colour pipeline.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned H_FP       = H_FP_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BP       = H_BP_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned V_FP       = V_FP_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BP       = V_BP_DEF,
  parameter int unsigned PIPE_DELAY = 2
) (
  input  logic               clk48,
  input  logic               rst,
  input  logic               pause_n,
  output logic [HPOS_W-1:0]  hpos,
  output logic [VPOS_W-1:0]  vpos,
  output logic               de_early,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame,
  output logic               hsync,
  output logic               vsync,
  output logic               de
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (HTotal > H_TOTAL_MAX) begin : gen_bad_htotal
    $fatal(1, "vga_timing_gen: H_TOTAL %0d exceeds %0d", HTotal, H_TOTAL_MAX);
  end
  if (VTotal > V_TOTAL_MAX) begin : gen_bad_vtotal
    $fatal(1, "vga_timing_gen: V_TOTAL %0d exceeds %0d", VTotal, V_TOTAL_MAX);
  end
  if (PIPE_DELAY > PIPE_DELAY_MAX) begin : gen_bad_delay
    $fatal(1, "vga_timing_gen: PIPE_DELAY %0d exceeds %0d", PIPE_DELAY, PIPE_DELAY_MAX);
  end

  localparam logic [HPOS_W-1:0] HLast   = HPOS_W'(HTotal - 1);
  localparam logic [VPOS_W-1:0] VLast   = VPOS_W'(VTotal - 1);
  localparam logic [HPOS_W-1:0] HActive = HPOS_W'(H_ACTIVE);
  localparam logic [VPOS_W-1:0] VActive = VPOS_W'(V_ACTIVE);

  logic [HPOS_W-1:0]  hpos_q, hpos_d;
  logic [VPOS_W-1:0]  vpos_q, vpos_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               h_wrap, v_wrap;
  sync_vec_t          raw, dly;

  always_comb begin
    h_wrap  = (hpos_q == HLast);
    v_wrap  = (vpos_q == VLast);
    hpos_d  = h_wrap ? '0 : hpos_q + HPOS_W'(1);
    vpos_d  = vpos_q;
    frame_d = frame_q;
    if (h_wrap) begin
      vpos_d = v_wrap ? '0 : vpos_q + VPOS_W'(1);
      // pause_n only matters on the edge that lands on (0,0)
      if (v_wrap && pause_n) begin
        frame_d = frame_q + FRAME_W'(1);
      end
    end
  end

  always_ff @(posedge clk48) begin
    if (rst) begin
      hpos_q  <= '0;
      vpos_q  <= '0;
      frame_q <= '0;
    end else begin
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      frame_q <= frame_d;
    end
  end

  // Gated by rst combinationally so the first cycle after release is already (0,0) live.
  assign de_early    = !rst && (hpos_q < HActive) && (vpos_q < VActive);
  assign line_start  = !rst && (hpos_q == '0);
  assign frame_start = line_start && (vpos_q == '0);

  always_comb begin
    raw = SYNC_IDLE;
    if (!rst) begin
      raw.hsync = !in_window(32'(hpos_q), H_ACTIVE + H_FP, H_SYNC);
      raw.vsync = !in_window(32'(vpos_q), V_ACTIVE + V_FP, V_SYNC);
      raw.de    = de_early;
    end
  end

  sync_delay_line #(
    .WIDTH ($bits(sync_vec_t)),
    .DEPTH (PIPE_DELAY)
  ) u_sync_delay (
    .clk_i     (clk48),
    .rst_i     (rst),
    .rst_val_i (SYNC_IDLE),
    .d_i       (raw),
    .q_o       (dly)
  );

  assign hpos  = hpos_q;
  assign vpos  = vpos_q;
  assign frame = frame_q;
  assign hsync = dly.hsync;
  assign vsync = dly.vsync;
  assign de    = dly.de;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: per-cycle raster model plus a queue modelling the
// delayed sync pins. Vertical timing is shortened so several frames fit in a short run.
module tb_vga_timing_gen;

  localparam int HA = 1220, HF = 30, HS = 183, HB = 92;
  localparam int HT = HA + HF + HS + HB;
  localparam int VA = 2, VF = 1, VS = 2, VB = 1;
  localparam int VT = VA + VF + VS + VB;
  localparam int PD = 2;
  localparam logic [2:0] PinsIdle = 3'b110;  // {hsync, vsync, de}

  logic        clk48 = 1'b0;
  logic        rst = 1'b1;
  logic        pause_n = 1'b1;
  logic [10:0] hpos;
  logic [9:0]  vpos;
  logic        de_early, line_start, frame_start;
  logic [15:0] frame;
  logic        hsync, vsync, de;

  always #5 clk48 = ~clk48;

  vga_timing_gen #(
    .H_ACTIVE   (HA),
    .H_FP       (HF),
    .H_SYNC     (HS),
    .H_BP       (HB),
    .V_ACTIVE   (VA),
    .V_FP       (VF),
    .V_SYNC     (VS),
    .V_BP       (VB),
    .PIPE_DELAY (PD)
  ) dut (
    .clk48       (clk48),
    .rst         (rst),
    .pause_n     (pause_n),
    .hpos        (hpos),
    .vpos        (vpos),
    .de_early    (de_early),
    .line_start  (line_start),
    .frame_start (frame_start),
    .frame       (frame),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de)
  );

  int          errors = 0;
  int          checks = 0;
  int          mh = 0, mv = 0;
  logic [15:0] mframe = 16'h0;
  logic [2:0]  pipe_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] raw_pins(input int h, input int v, input logic r);
    logic hs, vs, den;
    hs  = r || !(h >= HA + HF && h < HA + HF + HS);
    vs  = r || !(v >= VA + VF && v < VA + VF + VS);
    den = !r && h < HA && v < VA;
    return {hs, vs, den};
  endfunction

  // One clock: queue the raw vector entering the pipe, advance the model, then compare.
  task automatic tick();
    logic        r, p;
    logic [63:0] exp_raster;
    r = rst;
    p = pause_n;
    pipe_q.push_back(raw_pins(mh, mv, r));
    @(posedge clk48);
    #1;
    if (r) begin
      mh = 0;
      mv = 0;
      mframe = 16'h0;
      pipe_q.delete();
      repeat (PD) pipe_q.push_back(PinsIdle);
    end else begin
      void'(pipe_q.pop_front());
      if (mh == HT - 1) begin
        mh = 0;
        if (mv == VT - 1) begin
          mv = 0;
          if (p) mframe = mframe + 16'h1;
        end else begin
          mv++;
        end
      end else begin
        mh++;
      end
    end
    exp_raster = {24'h0, 11'(mh), 10'(mv), mframe, !rst && mh < HA && mv < VA,
                  !rst && mh == 0, !rst && mh == 0 && mv == 0};
    check("raster", {24'h0, hpos, vpos, frame, de_early, line_start, frame_start}, exp_raster);
    check("pins", 64'({hsync, vsync, de}), 64'(pipe_q[0]));
  endtask

  task automatic run_to(input int h, input int v);
    int n = 0;
    while (!(mh == h && mv == v) && n < 2 * VT * HT) begin
      tick();
      n++;
    end
    check("reach_pos", 64'({hpos, vpos}), 64'({11'(h), 10'(v)}));
  endtask

  task automatic next_frame();
    tick();
    run_to(0, 0);
  endtask

  initial begin
    int n, cnt_de_hi, cnt_de_lo, cnt_hs, first_hs, cnt_ls, cnt_fs, cnt_vs;
    logic [20:0] first_vs;

    // Reset release
    rst = 1'b1;
    pause_n = 1'b1;
    repeat (5) tick();
    check("rst_hsync", 64'(hsync), 64'd1);
    check("rst_vsync", 64'(vsync), 64'd1);
    check("rst_de", 64'(de), 64'd0);
    check("rst_frame", 64'(frame), 64'd0);
    check("rst_de_early", 64'(de_early), 64'd0);
    rst = 1'b0;
    #1;
    check("rel_pos", 64'({hpos, vpos}), 64'd0);
    check("rel_de_early", 64'(de_early), 64'd1);
    check("rel_frame_start", 64'(frame_start), 64'd1);
    check("rel_line_start", 64'(line_start), 64'd1);
    n = 0;
    while (de !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("de_latency", 64'(n), 64'd2);

    // Line timing over an active line
    run_to(0, 1);
    cnt_de_hi = 0; cnt_de_lo = 0; cnt_hs = 0; first_hs = -1; cnt_ls = 0;
    for (int i = 0; i < HT; i++) begin
      if (de_early === 1'b1) cnt_de_hi++;
      if (de_early === 1'b0) cnt_de_lo++;
      if (line_start === 1'b1) cnt_ls++;
      if (hsync === 1'b0) begin
        cnt_hs++;
        if (first_hs < 0) first_hs = int'(hpos);
      end
      tick();
    end
    check("line_de_hi", 64'(cnt_de_hi), 64'd1220);
    check("line_de_lo", 64'(cnt_de_lo), 64'd305);
    check("line_hs_len", 64'(cnt_hs), 64'd183);
    check("line_hs_edge", 64'(first_hs), 64'd1252);
    check("line_starts", 64'(cnt_ls), 64'd1);
    check("line_period", 64'({line_start, hpos, vpos}), 64'({1'b1, 11'd0, 10'd2}));

    // Frame timing
    run_to(0, 0);
    cnt_vs = 0; cnt_ls = 0; cnt_fs = 0; first_vs = '1;
    for (int i = 0; i < VT * HT; i++) begin
      if (line_start === 1'b1) cnt_ls++;
      if (frame_start === 1'b1) cnt_fs++;
      if (vsync === 1'b0) begin
        if (cnt_vs == 0) first_vs = {vpos, hpos};
        cnt_vs++;
      end
      tick();
    end
    check("frame_vs_len", 64'(cnt_vs), 64'd3050);
    check("frame_vs_edge", 64'(first_vs), 64'({10'(VA + VF), 11'd2}));
    check("frame_line_starts", 64'(cnt_ls), 64'(VT));
    check("frame_frame_starts", 64'(cnt_fs), 64'd1);
    check("frame_count2", 64'(frame), 64'd2);
    next_frame();
    check("frame_count3", 64'(frame), 64'd3);

    // Pause mid-frame, two frames held, then resume
    run_to(HT / 2, 3);
    pause_n = 1'b0;
    next_frame();
    check("pause_hold1", 64'(frame), 64'd3);
    next_frame();
    check("pause_hold2", 64'(frame), 64'd3);
    pause_n = 1'b1;
    next_frame();
    check("pause_resume", 64'(frame), 64'd4);

    // Counter wrap from a deposited 0xFFFF
    tick();
    dut.frame_q = 16'hFFFF;
    mframe = 16'hFFFF;
    #1;
    check("wrap_deposit", 64'(frame), 64'hFFFF);
    next_frame();
    check("wrap_zero", 64'(frame), 64'd0);

    // Reset in the middle of hsync and vsync
    run_to(1300, VA + VF + 1);
    check("mid_hsync_low", 64'(hsync), 64'd0);
    check("mid_vsync_low", 64'(vsync), 64'd0);
    rst = 1'b1;
    tick();
    check("mid_rst_pins", 64'({hsync, vsync, de}), 64'(PinsIdle));
    check("mid_rst_pos", 64'({hpos, vpos}), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("mid_rel_pos", 64'({hpos, vpos}), 64'd0);
    check("mid_rel_frame", 64'(frame), 64'd0);
    check("mid_rel_flags", 64'({de_early, line_start, frame_start}), 64'd7);
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
